core_wb_stage: RTL
==================

# core_wb_stage

Write-back stage of the RV32IMF pipeline, directly downstream of the memory stage. It takes the registered memory/writeback signals and the raw memory read data, formats load data (byte/half selection, sign/zero extension), and steers the result to the integer or FP register file. It raises a stall while a load's read data has not yet returned, and captures that data if it arrives while the pipeline is frozen. It also keeps a registered copy of the last committed write for forwarding.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register index width.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_regfile_waddr_i  in  5  destination register index.
- w_regfile_rd_i  in  32  ALU/FPU result for non-load instructions.
- w_regfile_wr_i  in  1  instruction writes a register.
- w_is_load_store_i  in  1  instruction is a load or a store.
- w_LOAD_op_i  in  3  load funct3: 000 LB, 001 LH, 010 LW/FLW, 100 LBU, 101 LHU.
- w_FP_OP_i  in  1  destination is the FP register file.
- w_addr_lsb_i  in  2  byte offset of the load address (addr[1:0]).
- w_data_rdata_i  in  32  raw memory read word.
- data_rvalid_i  in  1  read data valid this cycle.
- stall_general_i  in  1  global pipeline freeze.
- regfile_waddr_o  out  5  integer/FP write index.
- regfile_wdata_o  out  32  formatted write data.
- regfile_wr_o  out  1  integer register-file write enable.
- fp_regfile_wr_o  out  1  FP register-file write enable.
- wb_stall_o  out  1  load data pending; request pipeline stall.
- fwd_valid_o, fwd_fp_o  out  1 each  last committed write valid / targeted FP file.
- fwd_waddr_o  out  5; fwd_wdata_o  out  32  last committed write index/data.

## Operation
- is_load = w_is_load_store_i & w_regfile_wr_i. Stores are is_load_store with wr=0; they never write and never stall.
- State machine, two states:
  - IDLE: no captured data. IDLE->HOLD when is_load & data_rvalid_i & stall_general_i. The word is latched into a 32-bit buffer.
  - HOLD: buffer holds data for the current load. HOLD->IDLE when stall_general_i=0.
- Load source word: buffer in HOLD, otherwise w_data_rdata_i.
- Load formatting:
  - LB/LBU: byte at w_addr_lsb_i, sign- or zero-extended.
  - LH/LHU: halfword selected by w_addr_lsb_i[1], sign- or zero-extended. lsb[0] is ignored.
  - LW/FLW: full word. lsb is ignored.
  - Codes 011/110/111: full word.
- Non-load: regfile_wdata_o = w_regfile_rd_i.
- data_avail = !is_load | data_rvalid_i | (state==HOLD).
- Write enables (combinational):
  - regfile_wr_o = w_regfile_wr_i & !w_FP_OP_i & data_avail & (waddr!=0).
  - fp_regfile_wr_o = w_regfile_wr_i & w_FP_OP_i & data_avail. f0 is writable.
- Repeated identical writes while stall_general_i holds the inputs are permitted.
- wb_stall_o = is_load & !data_rvalid_i & (state!=HOLD).
- Forwarding register: updates on a clock edge where (regfile_wr_o|fp_regfile_wr_o) & !stall_general_i.
  - Loads fwd_valid_o=1, fwd_waddr_o, fwd_wdata_o, fwd_fp_o.
  - Otherwise it holds its value.
- data_rvalid_i with no load present, or while in HOLD, is ignored.

## Timing
- Reset (async): state=IDLE, buffer=0, fwd_valid_o=0, fwd_fp_o=0, fwd_waddr_o=0, fwd_wdata_o=0.
- Combinational outputs follow their inputs; under reset with all inputs 0 they are 0.
- Write latency: zero cycles. The write occurs in the same cycle data_rvalid_i is seen; forwarding registers update on the following edge.
- rvalid with stall_general_i=1: the write is asserted in that cycle and again every frozen cycle from the buffer, until the unfreeze edge.
- Reset asserted mid-HOLD: returns to IDLE immediately and the buffer is cleared.
- A simultaneous unfreeze and new rvalid in HOLD: the HOLD->IDLE transition wins. The new instruction is evaluated from IDLE on the next cycle.

## Test plan
- ALU write: wr=1, waddr=5, rd_i=0x1234_5678, not load -> regfile_wr_o=1, wdata=0x12345678. Next edge: fwd_valid=1, fwd_waddr=5.
- x0 write: waddr=0, wr=1 -> regfile_wr_o=0 and fwd unchanged. With FP_OP=1 and waddr=0 -> fp_regfile_wr_o=1.
- Load formatting, rdata=0x80FF_7F01:
  - LB lsb=3 -> 0xFFFFFF80.
  - LBU lsb=1 -> 0x0000007F.
  - LH lsb=2 -> 0xFFFF80FF.
  - LHU lsb=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Load latency: LW with rvalid low for 3 cycles -> wb_stall_o=1 and no write for those 3 cycles. Cycle 4 with rvalid=1 -> stall=0, regfile_wr_o=1.
- Frozen capture: FLW, rvalid pulses 1 cycle with stall_general_i=1 for 4 cycles, rdata then changes to garbage -> state HOLD, fp_regfile_wr_o=1 with the captured word for all frozen cycles, wb_stall_o=0. Returns to IDLE after the unfreeze.
- Store plus async reset: store with rvalid=1 -> no write, no stall, state IDLE. Assert rst_n=0 during HOLD -> state IDLE, fwd_valid_o=0 immediately.

Source files
------------

// File: rtl/core_wb_stage.sv
// Write-back stage: load formatting, register-file steering,
// load-data stall, frozen-pipeline capture and forwarding register.
module core_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] w_regfile_waddr_i,
  input  logic [DATA_WIDTH-1:0]     w_regfile_rd_i,
  input  logic                      w_regfile_wr_i,
  input  logic                      w_is_load_store_i,
  input  logic [2:0]                w_LOAD_op_i,
  input  logic                      w_FP_OP_i,
  input  logic [1:0]                w_addr_lsb_i,
  input  logic [DATA_WIDTH-1:0]     w_data_rdata_i,
  input  logic                      data_rvalid_i,
  input  logic                      stall_general_i,
  output logic [REG_ADDR_WIDTH-1:0] regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]     regfile_wdata_o,
  output logic                      regfile_wr_o,
  output logic                      fp_regfile_wr_o,
  output logic                      wb_stall_o,
  output logic                      fwd_valid_o,
  output logic                      fwd_fp_o,
  output logic [REG_ADDR_WIDTH-1:0] fwd_waddr_o,
  output logic [DATA_WIDTH-1:0]     fwd_wdata_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [DATA_WIDTH-1:0] hold_buf;
  logic [DATA_WIDTH-1:0] src;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  is_load;
  logic                  in_hold;
  logic                  data_avail;
  logic                  capture;
  logic                  commit;

  assign is_load = w_is_load_store_i & w_regfile_wr_i;
  assign in_hold = (state == HOLD);
  assign src     = in_hold ? hold_buf : w_data_rdata_i;
  assign capture = ~in_hold & is_load & data_rvalid_i & stall_general_i;

  always_comb begin
    ld_byte = src[7:0];
    unique case (w_addr_lsb_i)
      2'd0: ld_byte = src[7:0];
      2'd1: ld_byte = src[15:8];
      2'd2: ld_byte = src[23:16];
      2'd3: ld_byte = src[31:24];
    endcase
  end

  assign ld_half = w_addr_lsb_i[1] ? src[31:16] : src[15:0];

  always_comb begin
    ld_data = src;
    unique case (1'b1)
      w_LOAD_op_i == OP_LB:
        ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      w_LOAD_op_i == OP_LBU:
        ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      w_LOAD_op_i == OP_LH:
        ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      w_LOAD_op_i == OP_LHU:
        ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default:
        ld_data = src;
    endcase
  end

  assign data_avail = ~is_load | data_rvalid_i | in_hold;

  assign regfile_waddr_o = w_regfile_waddr_i;
  assign regfile_wdata_o = is_load ? ld_data : w_regfile_rd_i;
  assign regfile_wr_o    = w_regfile_wr_i & ~w_FP_OP_i & data_avail
                         & (w_regfile_waddr_i != '0);
  assign fp_regfile_wr_o = w_regfile_wr_i & w_FP_OP_i & data_avail;
  assign wb_stall_o      = is_load & ~data_rvalid_i & ~in_hold;

  assign commit = (regfile_wr_o | fp_regfile_wr_o) & ~stall_general_i;

  // Unfreeze leaves HOLD even if a new rvalid shows up that cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (capture) state_nxt = HOLD;
      HOLD:    if (!stall_general_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_buf <= '0;
    end else begin
      state <= state_nxt;
      if (capture) hold_buf <= w_data_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_o <= 1'b0;
      fwd_fp_o    <= 1'b0;
      fwd_waddr_o <= '0;
      fwd_wdata_o <= '0;
    end else if (commit) begin
      fwd_valid_o <= 1'b1;
      fwd_fp_o    <= w_FP_OP_i;
      fwd_waddr_o <= w_regfile_waddr_i;
      fwd_wdata_o <= regfile_wdata_o;
    end
  end

endmodule
